// File: rtl/tdes_ahb_slave.sv
// AHB-Lite slave front end for the Triple-DES accelerator.
// Decodes bus writes into mode/key/data registers, pulses the core start,
// returns result/status on reads, stalls while the core is busy and gives
// the two-cycle ERROR response on illegal accesses.
module tdes_ahb_slave #(
   parameter logic [27:0] BASE_ADDR    = 28'hAAAAAAA,
   parameter bit          CHECK_HTRANS = 1'b0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [63:0] HWDATA,
   output logic [63:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic        enc_dec,
   output logic [63:0] key1,
   output logic [63:0] key2,
   output logic [63:0] key3,
   output logic [63:0] data_in,
   output logic        start,
   input  logic [63:0] data_out,
   input  logic        done
);

   localparam logic [3:0] OFF_MODE   = 4'd0;
   localparam logic [3:0] OFF_KEY1   = 4'd1;
   localparam logic [3:0] OFF_KEY2   = 4'd2;
   localparam logic [3:0] OFF_KEY3   = 4'd3;
   localparam logic [3:0] OFF_DATA   = 4'd4;
   localparam logic [3:0] OFF_RESULT = 4'd5;
   localparam logic [3:0] OFF_STATUS = 4'd6;

   // ST_IDLE covers both "no transfer" and a zero-wait data phase (dp_valid_r)
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STALL = 2'd1,
      ST_ERR1  = 2'd2,
      ST_ERR2  = 2'd3
   } state_t;

   // Offsets 7-F, writes to read-only regs, reads of write-only regs and
   // non-64-bit sizes to the 64-bit regs are refused.
   function automatic logic access_illegal(input logic [3:0] off, input logic wr, input logic [2:0] size);
      logic bad;
      if (off > OFF_STATUS) bad = 1'b1;
      else if (wr && (off >= OFF_RESULT)) bad = 1'b1;
      else if (!wr && (off <= OFF_DATA)) bad = 1'b1;
      else if ((off >= OFF_KEY1) && (off <= OFF_RESULT) && (size != 3'b011)) bad = 1'b1;
      else bad = 1'b0;
      return bad;
   endfunction

   state_t      state_r, state_nxt_s;
   logic        dp_valid_r, dp_valid_nxt_s;
   logic        dp_write_r, dp_write_nxt_s;
   logic [3:0]  dp_off_r, dp_off_nxt_s;
   logic        busy_r, busy_nxt_s;
   logic        rv_r, rv_nxt_s;
   logic [63:0] result_r, result_nxt_s;
   logic [63:0] hrdata_r, hrdata_nxt_s;
   logic        hreadyout_r, hreadyout_nxt_s;
   logic        hresp_r, hresp_nxt_s;
   logic        enc_dec_r, start_r;
   logic [63:0] key1_r, key2_r, key3_r, data_in_r;

   logic addr_hit_s, wr_done_s, rd_done_s, core_done_s, start_data_s, stall_req_s;
   logic unused_s;

   assign unused_s     = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
   assign addr_hit_s   = HSEL & HREADY & (HADDR[31:4] == BASE_ADDR) & (CHECK_HTRANS ? HTRANS[1] : 1'b1);
   assign wr_done_s    = (state_r == ST_IDLE) & dp_valid_r & dp_write_r;
   assign rd_done_s    = (state_r == ST_IDLE) & dp_valid_r & ~dp_write_r;
   assign core_done_s  = done & busy_r;
   assign start_data_s = wr_done_s & (dp_off_r == OFF_DATA);
   // Stall is judged against the busy value that will hold in the data phase
   assign stall_req_s  = busy_nxt_s & ((HWRITE & (HADDR[3:0] == OFF_DATA)) |
                                       (~HWRITE & (HADDR[3:0] == OFF_RESULT)));

   // Next values of core status and result registers
   always_comb begin
      busy_nxt_s   = busy_r;
      rv_nxt_s     = rv_r;
      result_nxt_s = result_r;
      if (start_data_s) busy_nxt_s = 1'b1;
      else if (core_done_s) busy_nxt_s = 1'b0;
      else busy_nxt_s = busy_r;
      if (core_done_s) begin
         rv_nxt_s     = 1'b1;
         result_nxt_s = data_out;
      end else if (rd_done_s && (dp_off_r == OFF_RESULT)) begin
         rv_nxt_s = 1'b0;
      end else begin
         rv_nxt_s = rv_r;
      end
   end

   // Transfer FSM next state and registered bus response values
   always_comb begin
      state_nxt_s    = state_r;
      dp_valid_nxt_s = 1'b0;
      dp_write_nxt_s = dp_write_r;
      dp_off_nxt_s   = dp_off_r;
      hrdata_nxt_s   = 64'd0;
      case (state_r)
         ST_STALL: begin
            dp_valid_nxt_s = 1'b1;
            if (core_done_s) state_nxt_s = ST_IDLE;
            else state_nxt_s = ST_STALL;
         end
         ST_ERR1: state_nxt_s = ST_ERR2;
         ST_IDLE, ST_ERR2: begin
            if (addr_hit_s) begin
               dp_write_nxt_s = HWRITE;
               dp_off_nxt_s   = HADDR[3:0];
               if (access_illegal(HADDR[3:0], HWRITE, HSIZE)) begin
                  state_nxt_s = ST_ERR1;
               end else if (stall_req_s) begin
                  state_nxt_s    = ST_STALL;
                  dp_valid_nxt_s = 1'b1;
               end else begin
                  state_nxt_s    = ST_IDLE;
                  dp_valid_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
      hreadyout_nxt_s = ~((state_nxt_s == ST_STALL) | (state_nxt_s == ST_ERR1));
      hresp_nxt_s     = (state_nxt_s == ST_ERR1) | (state_nxt_s == ST_ERR2);
      if ((state_nxt_s == ST_IDLE) && dp_valid_nxt_s && !dp_write_nxt_s) begin
         case (dp_off_nxt_s)
            OFF_RESULT: hrdata_nxt_s = result_nxt_s;
            OFF_STATUS: hrdata_nxt_s = {62'd0, rv_nxt_s, busy_nxt_s};
            default:    hrdata_nxt_s = 64'd0;
         endcase
      end else begin
         hrdata_nxt_s = 64'd0;
      end
   end

   // FSM, data-phase attributes, status and bus response registers
   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state_r     <= ST_IDLE;
         dp_valid_r  <= 1'b0;
         dp_write_r  <= 1'b0;
         dp_off_r    <= 4'd0;
         busy_r      <= 1'b0;
         rv_r        <= 1'b0;
         result_r    <= 64'd0;
         hrdata_r    <= 64'd0;
         hreadyout_r <= 1'b1;
         hresp_r     <= 1'b0;
         start_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         dp_valid_r  <= dp_valid_nxt_s;
         dp_write_r  <= dp_write_nxt_s;
         dp_off_r    <= dp_off_nxt_s;
         busy_r      <= busy_nxt_s;
         rv_r        <= rv_nxt_s;
         result_r    <= result_nxt_s;
         hrdata_r    <= hrdata_nxt_s;
         hreadyout_r <= hreadyout_nxt_s;
         hresp_r     <= hresp_nxt_s;
         start_r     <= start_data_s;
      end
   end

   // Configuration and data registers load at the end of a completed write
   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         enc_dec_r <= 1'b0;
         key1_r    <= 64'd0;
         key2_r    <= 64'd0;
         key3_r    <= 64'd0;
         data_in_r <= 64'd0;
      end else if (wr_done_s) begin
         case (dp_off_r)
            OFF_MODE: enc_dec_r <= HWDATA[0];
            OFF_KEY1: key1_r    <= HWDATA;
            OFF_KEY2: key2_r    <= HWDATA;
            OFF_KEY3: key3_r    <= HWDATA;
            OFF_DATA: data_in_r <= HWDATA;
            default:  ;
         endcase
      end
   end

   assign HRDATA    = hrdata_r;
   assign HREADYOUT = hreadyout_r;
   assign HRESP     = hresp_r;
   assign enc_dec   = enc_dec_r;
   assign key1      = key1_r;
   assign key2      = key2_r;
   assign key3      = key3_r;
   assign data_in   = data_in_r;
   assign start     = start_r;

endmodule

// File: tb/tb_tdes_ahb_slave.sv
// Self-checking bench for tdes_ahb_slave: vector table of single transfers
// plus hand sequences for stalls, back-to-back access and reset mid-operation.
module tb_tdes_ahb_slave;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic        HREADY;
   logic [63:0] HWDATA;
   logic [63:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic        enc_dec;
   logic [63:0] key1, key2, key3, data_in;
   logic        start;
   logic [63:0] data_out;
   logic        done;

   int checks = 0;
   int fails  = 0;
   int start_cnt = 0;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   tdes_ahb_slave dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .enc_dec(enc_dec), .key1(key1),
      .key2(key2), .key3(key3), .data_in(data_in), .start(start),
      .data_out(data_out), .done(done)
   );

   // Count start pulses seen on clock edges
   always @(posedge HCLK) if (start) start_cnt++;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [63:0] wdata;
      logic        exp_resp;
      int          exp_waits;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [63:0] wdata, output logic [63:0] rdata,
                           output logic resp, output int waits);
      logic fin;
      HSEL = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = size;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HADDR = 32'd0; HWRITE = 1'b0; HSIZE = 3'b000; HWDATA = wdata;
      waits = 0; resp = 1'b0; rdata = 64'd0; fin = 1'b0;
      while (!fin) begin
         @(negedge HCLK);
         if (HRESP) resp = 1'b1;
         if (HREADYOUT) begin
            rdata = HRDATA;
            fin = 1'b1;
         end else begin
            waits++;
            if (waits > 64) begin
               checks++; fails++;
               $display("FAIL xfer_timeout: actual %0d wait states required at most 64", waits);
               fin = 1'b1;
            end
         end
      end
      @(posedge HCLK); #1;
      HWDATA = 64'd0;
   endtask

   task automatic pulse_done(input int delay, input logic [63:0] value);
      repeat (delay) @(posedge HCLK);
      #1; data_out = value; done = 1'b1;
      @(posedge HCLK); #1; done = 1'b0;
   endtask

   logic [63:0] rd;
   logic        rsp;
   int          wt;

   initial begin
      vecs[0]  = '{"mode_w",        32'hAAAAAAA0, 1'b1, 3'b011, 64'h1,                  1'b0, 0, 64'h0};
      vecs[1]  = '{"key1_w",        32'hAAAAAAA1, 1'b1, 3'b011, 64'h1111111111111111,   1'b0, 0, 64'h0};
      vecs[2]  = '{"key2_w",        32'hAAAAAAA2, 1'b1, 3'b011, 64'h2222222222222222,   1'b0, 0, 64'h0};
      vecs[3]  = '{"key3_w",        32'hAAAAAAA3, 1'b1, 3'b011, 64'h3333333333333333,   1'b0, 0, 64'h0};
      vecs[4]  = '{"status_idle",   32'hAAAAAAA6, 1'b0, 3'b011, 64'h0,                  1'b0, 0, 64'h0};
      vecs[5]  = '{"rd_mode_err",   32'hAAAAAAA0, 1'b0, 3'b011, 64'h0,                  1'b1, 1, 64'h0};
      vecs[6]  = '{"rd_data_err",   32'hAAAAAAA4, 1'b0, 3'b011, 64'h0,                  1'b1, 1, 64'h0};
      vecs[7]  = '{"wr_result_err", 32'hAAAAAAA5, 1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFF,   1'b1, 1, 64'h0};
      vecs[8]  = '{"wr_status_err", 32'hAAAAAAA6, 1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFF,   1'b1, 1, 64'h0};
      vecs[9]  = '{"rd_unmapped7",  32'hAAAAAAA7, 1'b0, 3'b011, 64'h0,                  1'b1, 1, 64'h0};
      vecs[10] = '{"acc_unmapped8", 32'hAAAAAAA8, 1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFF,   1'b1, 1, 64'h0};
      vecs[11] = '{"key1_size_err", 32'hAAAAAAA1, 1'b1, 3'b010, 64'hFFFFFFFFFFFFFFFF,   1'b1, 1, 64'h0};
      vecs[12] = '{"miss_addr",     32'hBAAAAAA1, 1'b1, 3'b011, 64'hDEADDEADDEADDEAD,   1'b0, 0, 64'h0};
      vecs[13] = '{"mode_size2",    32'hAAAAAAA0, 1'b1, 3'b010, 64'h0,                  1'b0, 0, 64'h0};
      vecs[14] = '{"mode_w1",       32'hAAAAAAA0, 1'b1, 3'b011, 64'h1,                  1'b0, 0, 64'h0};

      HRESET = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HWRITE = 1'b0; HTRANS = 2'b00;
      HSIZE = 3'b000; HBURST = 3'b000; HPROT = 4'h0; HMASTLOCK = 1'b0;
      HWDATA = 64'd0; data_out = 64'd0; done = 1'b0;

      // Reset state
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
      chk("rst_hresp",     {63'd0, HRESP},     64'd0);
      chk("rst_hrdata",    HRDATA,             64'd0);
      chk("rst_outputs",   {62'd0, enc_dec, start}, 64'd0);
      HRESET = 1'b1;
      @(posedge HCLK); #1;

      // Table of single transfers
      for (int i = 0; i < 15; i++) begin
         ahb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].wdata, rd, rsp, wt);
         chk({vecs[i].name, "_resp"},  {63'd0, rsp},     {63'd0, vecs[i].exp_resp});
         chk({vecs[i].name, "_waits"}, 64'(wt),          64'(vecs[i].exp_waits));
         chk({vecs[i].name, "_rdata"}, rd,               vecs[i].exp_rdata);
         if (i == 13) chk("mode_size2_effect", {63'd0, enc_dec}, 64'd0);
      end
      chk("enc_dec", {63'd0, enc_dec}, 64'd1);
      chk("key1", key1, 64'h1111111111111111);
      chk("key2", key2, 64'h2222222222222222);
      chk("key3", key3, 64'h3333333333333333);
      chk("data_in_idle", data_in, 64'd0);
      chk("no_start_yet", 64'(start_cnt), 64'd0);

      // Start an operation
      ahb_xfer(32'hAAAAAAA4, 1'b1, 3'b011, 64'h1234567890ABCDEF, rd, rsp, wt);
      chk("start_after_dp", {63'd0, start}, 64'd1);
      chk("data_in_1", data_in, 64'h1234567890ABCDEF);
      @(posedge HCLK); #1;
      chk("start_one_cycle", {63'd0, start}, 64'd0);
      chk("start_cnt_1", 64'(start_cnt), 64'd1);
      ahb_xfer(32'hAAAAAAA6, 1'b0, 3'b011, 64'd0, rd, rsp, wt);
      chk("status_busy", rd, 64'h1);

      // Key write while busy is immediate
      ahb_xfer(32'hAAAAAAA1, 1'b1, 3'b011, 64'h5555555555555555, rd, rsp, wt);
      chk("key_busy_waits", 64'(wt), 64'd0);
      chk("key1_busy", key1, 64'h5555555555555555);

      // DATA_IN write while busy stalls until done, then restarts
      fork
         ahb_xfer(32'hAAAAAAA4, 1'b1, 3'b011, 64'h4444444444444444, rd, rsp, wt);
         pulse_done(3, 64'hCAFEF00DDEADBEEF);
      join
      chk("wr_stall_waits", 64'(wt), 64'd3);
      chk("wr_stall_resp", {63'd0, rsp}, 64'd0);
      chk("restart_start", {63'd0, start}, 64'd1);
      chk("data_in_2", data_in, 64'h4444444444444444);
      @(posedge HCLK); #1;
      chk("start_cnt_2", 64'(start_cnt), 64'd2);
      ahb_xfer(32'hAAAAAAA6, 1'b0, 3'b011, 64'd0, rd, rsp, wt);
      chk("status_busy_valid", rd, 64'h3);

      // RESULT read while busy stalls and returns the new result
      fork
         ahb_xfer(32'hAAAAAAA5, 1'b0, 3'b011, 64'd0, rd, rsp, wt);
         pulse_done(3, 64'h0123456789ABCDEF);
      join
      chk("rd_stall_waits", 64'(wt), 64'd3);
      chk("rd_stall_data", rd, 64'h0123456789ABCDEF);
      ahb_xfer(32'hAAAAAAA6, 1'b0, 3'b011, 64'd0, rd, rsp, wt);
      chk("status_cleared", rd, 64'h0);

      // Back-to-back DATA_IN write then STATUS read
      HSEL = 1'b1; HADDR = 32'hAAAAAAA4; HWRITE = 1'b1; HSIZE = 3'b011;
      @(posedge HCLK); #1;
      HWDATA = 64'h0BADC0DE00000001; HADDR = 32'hAAAAAAA6; HWRITE = 1'b0;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HADDR = 32'd0; HWDATA = 64'd0; HSIZE = 3'b000;
      chk("b2b_start", {63'd0, start}, 64'd1);
      @(negedge HCLK);
      chk("b2b_ready", {63'd0, HREADYOUT}, 64'd1);
      chk("b2b_status", HRDATA, 64'h1);
      @(posedge HCLK); #1;
      chk("start_cnt_3", 64'(start_cnt), 64'd3);

      // Asynchronous reset while busy
      #2; HRESET = 1'b0;
      #1;
      chk("arst_keys", key1 | key2 | key3, 64'd0);
      chk("arst_data_in", data_in, 64'd0);
      chk("arst_ctrl", {61'd0, enc_dec, start, HRESP}, 64'd0);
      chk("arst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
      chk("arst_hrdata", HRDATA, 64'd0);
      repeat (2) @(posedge HCLK);
      #1; HRESET = 1'b1;
      pulse_done(1, 64'hFFFFFFFFFFFFFFFF);
      ahb_xfer(32'hAAAAAAA6, 1'b0, 3'b011, 64'd0, rd, rsp, wt);
      chk("post_rst_status", rd, 64'h0);
      ahb_xfer(32'hAAAAAAA5, 1'b0, 3'b011, 64'd0, rd, rsp, wt);
      chk("post_rst_result_waits", 64'(wt), 64'd0);
      chk("post_rst_result", rd, 64'h0);
      chk("post_rst_start_cnt", 64'(start_cnt), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
